// File: rtl/c6_pkg.sv
// Shared definitions for the two-requester modulus arbiter and its remainder engine.
package c6_pkg;
  localparam int DATAWIDTH_DEFAULT = 64;
  localparam int ID_W              = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/mod_iter.sv
// Iterative restoring-remainder engine: one dividend bit per cycle, MSB first.
// The done pulse and rem are combinational in the final iteration cycle.
module mod_iter #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] c,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] rem
);
  localparam int CNT_W = $clog2(DATAWIDTH);

  logic [DATAWIDTH-1:0] a_q, c_q, rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic [DATAWIDTH:0]   shifted, trial;

  // With c==0 the compare always passes but subtracts nothing, so the
  // dividend bits simply shift through and the result is a itself.
  always_comb begin
    shifted = {rem_q, a_q[DATAWIDTH-1]};
    trial   = shifted - {1'b0, c_q};
    rem_d   = (shifted >= {1'b0, c_q}) ? trial[DATAWIDTH-1:0] : shifted[DATAWIDTH-1:0];
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(DATAWIDTH - 1));
  assign rem  = rem_d;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a_q    <= '0;
      c_q    <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      c_q    <= c;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      a_q   <= {a_q[DATAWIDTH-2:0], 1'b0};
      rem_q <= rem_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/c6_mod_arbiter.sv
// Round-robin arbiter sharing one iterative modulus engine between two requesters;
// computes z = (a % c == zero) ? a-1 : c+1 and returns it on a registered, id-tagged response.
module c6_mod_arbiter
  import c6_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] zero,
  input  logic                 req0_valid,
  input  logic [DATAWIDTH-1:0] req0_a,
  input  logic [DATAWIDTH-1:0] req0_c,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATAWIDTH-1:0] req1_a,
  input  logic [DATAWIDTH-1:0] req1_c,
  output logic                 req1_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [DATAWIDTH-1:0] rsp_z,
  input  logic                 rsp_ready
);
  state_e               state_q, state_d;
  logic [DATAWIDTH-1:0] a_q, c_q, zero_q, rsp_z_q, z_d;
  logic [ID_W-1:0]      id_q, last_grant_q, rsp_id_q, grant;
  logic                 rsp_valid_q, accept;
  logic [DATAWIDTH-1:0] acc_a, acc_c, eng_rem;
  logic                 eng_busy, eng_done;

  // Alternate on contention; a lone requester always wins.
  assign grant = (req0_valid && req1_valid) ? ~last_grant_q : ID_W'(req1_valid);
  assign acc_a = grant[0] ? req1_a : req0_a;
  assign acc_c = grant[0] ? req1_c : req0_c;

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (!eng_busy) begin
          req0_ready = req0_valid && !grant[0];
          req1_ready = req1_valid &&  grant[0];
        end
        if (req0_ready || req1_ready) state_d = RUN;
      end
      RUN:     if (eng_done) state_d = RESP;
      RESP:    if (rsp_valid_q && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = req0_ready || req1_ready;
  assign z_d    = (eng_rem == zero_q) ? (a_q - DATAWIDTH'(1)) : (c_q + DATAWIDTH'(1));

  mod_iter #(.DATAWIDTH(DATAWIDTH)) u_mod_iter (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (accept),
    .a     (acc_a),
    .c     (acc_c),
    .busy  (eng_busy),
    .done  (eng_done),
    .rem   (eng_rem)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      c_q          <= '0;
      zero_q       <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(1);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_z_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q          <= acc_a;
        c_q          <= acc_c;
        zero_q       <= zero;
        id_q         <= grant;
        last_grant_q <= grant;
      end
      if (eng_done) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_z_q     <= z_d;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
endmodule
